// File: rtl/sa_input_feeder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sa_input_feeder_pkg                                        |
// | Description : Feeder FSM encoding shared by the systolic-array feeder.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package sa_input_feeder_pkg;

   localparam int FD_IDLE_B     = 0;
   localparam int FD_FEED_B     = 1;
   localparam int FD_HALT_B     = 2;
   localparam int FD_DRAIN_B    = 3;
   localparam int FD_FINI_B     = 4;
   localparam int FD_NUM_STATES = 5;

   typedef enum logic [FD_NUM_STATES-1:0] {
      FD_IDLE  = 5'b00001,
      FD_FEED  = 5'b00010,
      FD_HALT  = 5'b00100,
      FD_DRAIN = 5'b01000,
      FD_FINI  = 5'b10000
   } sa_feeder_state_t;

endpackage
`default_nettype wire

// File: rtl/sa_input_feeder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sa_input_feeder_if                                         |
// | Description : Control, operand-buffer and array-edge signals of feeder.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface sa_input_feeder_if #(
   parameter int ARR_H  = 4,
   parameter int DATA_W = 8,
   parameter int ADDR_W = 10,
   parameter int K_W    = 8
);
   logic                    start;
   logic [ADDR_W-1:0]       base_addr;
   logic [K_W-1:0]          k_len;
   logic                    busy;
   logic                    done;
   logic                    rd_en;
   logic [ADDR_W-1:0]       rd_addr;
   logic [ARR_H*DATA_W-1:0] rd_data;
   logic                    sa_halt;
   logic                    feed_valid;
   logic [ARR_H*DATA_W-1:0] feed_data;

   modport master (
      input  start, base_addr, k_len, rd_data, sa_halt,
      output busy, done, rd_en, rd_addr, feed_valid, feed_data
   );

   modport slave (
      output start, base_addr, k_len, rd_data, sa_halt,
      input  busy, done, rd_en, rd_addr, feed_valid, feed_data
   );
endinterface
`default_nettype wire

// File: rtl/sa_input_feeder_skew_line.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sa_skew_line                                               |
// | Description : Valid-tagged delay line of DEPTH advance cycles per lane.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sa_skew_line #(
   parameter int DEPTH  = 0,
   parameter int DATA_W = 8
) (
   input  wire logic              clk,
   input  wire logic              rst,
   input  wire logic              en,
   input  wire logic              hold,
   input  wire logic              vld_in,
   input  wire logic [DATA_W-1:0] data_in,
   output logic      [DATA_W-1:0] data_out
);
   logic [DATA_W-1:0] w_tap;
   logic [DATA_W-1:0] r_hold;

   generate
      if (DEPTH == 0) begin : g_pass
         assign w_tap = vld_in ? data_in : '0;
      end else begin : g_shift
         logic [DEPTH-1:0]  r_vld;
         logic [DATA_W-1:0] r_dat [DEPTH];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_vld <= '0;
               for (int s = 0; s < DEPTH; s++) r_dat[s] <= '0;
            end else if (en) begin
               r_vld[0] <= vld_in;
               r_dat[0] <= data_in;
               for (int s = 1; s < DEPTH; s++) begin
                  r_vld[s] <= r_vld[s-1];
                  r_dat[s] <= r_dat[s-1];
               end
            end
         end

         assign w_tap = r_vld[DEPTH-1] ? r_dat[DEPTH-1] : '0;
      end
   endgenerate

   // Last advanced value is replayed while the array is halted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)     r_hold <= '0;
      else if (en) r_hold <= w_tap;
   end

   assign data_out = hold ? r_hold : w_tap;
endmodule
`default_nettype wire

// File: rtl/sa_input_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sa_input_feeder                                            |
// | Description : Reads K operand columns and feeds them diagonally skewed.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sa_input_feeder
   import sa_input_feeder_pkg::*;
#(
   parameter int ARR_H  = 4,
   parameter int DATA_W = 8,
   parameter int ADDR_W = 10,
   parameter int K_W    = 8
) (
   input  wire logic         clk,
   input  wire logic         rst,
   sa_input_feeder_if.master bus
);
   localparam int c_DRN_W = (ARR_H > 2) ? $clog2(ARR_H - 1) : 1;
   localparam logic [c_DRN_W-1:0] c_DRN_LAST = c_DRN_W'((ARR_H > 1) ? ARR_H - 2 : 0);

   sa_feeder_state_t        r_state, w_state_nxt;
   sa_feeder_state_t        r_saved, w_saved_nxt;
   logic [ADDR_W-1:0]       r_base;
   logic [K_W-1:0]          r_klen;
   logic [K_W-1:0]          r_rd_cnt;
   logic [K_W-1:0]          r_col_cnt;
   logic [c_DRN_W-1:0]      r_drn_cnt;
   logic                    r_rd_pend;
   logic                    r_skid_vld;
   logic [ARR_H*DATA_W-1:0] r_skid;

   logic                    w_feed_eff, w_drain_eff, w_adv, w_halted;
   logic                    w_rd_en, w_in_vld, w_last_col, w_last_drn;
   logic                    w_busy, w_done;
   logic [ARR_H*DATA_W-1:0] w_in_data;
   logic [ARR_H*DATA_W-1:0] w_feed_data;

   // A HALT cycle with sa_halt already released runs as the saved state,
   // so a halt of N cycles costs exactly N cycles.
   assign w_feed_eff  = (r_state == FD_FEED)  || ((r_state == FD_HALT) && (r_saved == FD_FEED));
   assign w_drain_eff = (r_state == FD_DRAIN) || ((r_state == FD_HALT) && (r_saved == FD_DRAIN));
   assign w_adv       = (w_feed_eff || w_drain_eff) && !bus.sa_halt;
   assign w_halted    = (w_feed_eff || w_drain_eff) && bus.sa_halt;
   assign w_rd_en     = w_feed_eff && !bus.sa_halt && (r_rd_cnt < r_klen);
   assign w_in_vld    = r_rd_pend || r_skid_vld;
   assign w_in_data   = r_skid_vld ? r_skid : bus.rd_data;
   assign w_last_col  = w_adv && w_in_vld && (r_col_cnt == r_klen - K_W'(1));
   assign w_last_drn  = w_adv && w_drain_eff && (r_drn_cnt == c_DRN_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= FD_IDLE;
         r_saved <= FD_IDLE;
      end else begin
         r_state <= w_state_nxt;
         r_saved <= w_saved_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_saved_nxt = r_saved;
      w_busy      = 1'b1;
      w_done      = 1'b0;
      case (r_state)
         FD_IDLE: begin
            w_busy = 1'b0;
            if (bus.start) w_state_nxt = (bus.k_len == '0) ? FD_FINI : FD_FEED;
         end
         FD_FEED, FD_HALT, FD_DRAIN: begin
            if (bus.sa_halt) begin
               w_state_nxt = FD_HALT;
               w_saved_nxt = w_feed_eff ? FD_FEED : FD_DRAIN;
            end else if (w_feed_eff) begin
               if (w_last_col) w_state_nxt = (ARR_H > 1) ? FD_DRAIN : FD_FINI;
               else            w_state_nxt = FD_FEED;
            end else if (w_last_drn) begin
               w_state_nxt = FD_FINI;
            end else begin
               w_state_nxt = FD_DRAIN;
            end
         end
         FD_FINI: begin
            w_done      = 1'b1;
            w_state_nxt = FD_IDLE;
         end
         default: w_state_nxt = FD_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_base     <= '0;
         r_klen     <= '0;
         r_rd_cnt   <= '0;
         r_col_cnt  <= '0;
         r_drn_cnt  <= '0;
         r_rd_pend  <= 1'b0;
         r_skid_vld <= 1'b0;
         r_skid     <= '0;
      end else begin
         if ((r_state == FD_IDLE) && bus.start) begin
            r_base    <= bus.base_addr;
            r_klen    <= bus.k_len;
            r_rd_cnt  <= '0;
            r_col_cnt <= '0;
            r_drn_cnt <= '0;
         end
         if (w_rd_en)               r_rd_cnt  <= r_rd_cnt + K_W'(1);
         if (w_adv && w_in_vld)     r_col_cnt <= r_col_cnt + K_W'(1);
         if (w_adv && w_drain_eff)  r_drn_cnt <= r_drn_cnt + c_DRN_W'(1);
         r_rd_pend <= w_rd_en;
         // rd_en only fires on advance cycles, so at most one word is ever parked.
         if (r_rd_pend && !w_adv) begin
            r_skid_vld <= 1'b1;
            r_skid     <= bus.rd_data;
         end else if (w_adv) begin
            r_skid_vld <= 1'b0;
         end
      end
   end

   generate
      for (genvar i = 0; i < ARR_H; i++) begin : g_lane
         sa_skew_line #(
            .DEPTH  (i),
            .DATA_W (DATA_W)
         ) u_line (
            .clk      (clk),
            .rst      (rst),
            .en       (w_adv),
            .hold     (w_halted),
            .vld_in   (w_in_vld),
            .data_in  (w_in_data[i*DATA_W +: DATA_W]),
            .data_out (w_feed_data[i*DATA_W +: DATA_W])
         );
      end
   endgenerate

   assign bus.busy       = w_busy;
   assign bus.done       = w_done;
   assign bus.rd_en      = w_rd_en;
   assign bus.rd_addr    = r_base + ADDR_W'(r_rd_cnt);
   assign bus.feed_valid = w_adv && (w_in_vld || w_drain_eff);
   assign bus.feed_data  = w_feed_data;
endmodule
`default_nettype wire
